// File: rtl/secuenciador_operaciones.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : secuenciador_operaciones
// Brief  : Sequences one request at a time into the 4-bit adder and returns
//          its Q/RCO. Optional SECUENCIADOR_AUTOCLEAR_EN adds a clear cycle.
// Rev    : 1.0
// ============================================================================
module secuenciador_operaciones #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [1:0]       i_req_op,
   input  logic [WIDTH-1:0] i_req_a,
   input  logic [WIDTH-1:0] i_req_b,
   input  logic             i_req_cin,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic             o_cin,
   output logic             o_enb,
   output logic [1:0]       o_modo,
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_rco,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [WIDTH-1:0] o_res_q,
   output logic             o_res_rco
);

   localparam logic [2:0] c_IDLE  = 3'd0;
`ifdef SECUENCIADOR_AUTOCLEAR_EN
   localparam logic [2:0] c_CLEAR = 3'd1;
`endif
   localparam logic [2:0] c_EXEC  = 3'd2;
   localparam logic [2:0] c_WAIT  = 3'd3;
   localparam logic [2:0] c_RESP  = 3'd4;

   localparam logic [1:0] c_MODO_HOLD  = 2'b00;
   localparam logic [1:0] c_MODO_CLEAR = 2'b11;

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_res_q;
   logic             r_res_rco;
   logic             w_accept;

   // Ready is masked by reset so nothing is accepted while it is asserted
   assign o_req_ready = (r_state == c_IDLE) && !rst;
   assign w_accept    = i_req_valid && o_req_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               case (i_req_op)
                  2'b00:   w_state_nxt = c_WAIT;
                  2'b11:   w_state_nxt = c_EXEC;
`ifdef SECUENCIADOR_AUTOCLEAR_EN
                  default: w_state_nxt = c_CLEAR;
`else
                  default: w_state_nxt = c_EXEC;
`endif
               endcase
            end
         end
`ifdef SECUENCIADOR_AUTOCLEAR_EN
         c_CLEAR: w_state_nxt = c_EXEC;
`endif
         c_EXEC:  w_state_nxt = c_WAIT;
         c_WAIT:  w_state_nxt = c_RESP;
         c_RESP: begin
            if (i_res_ready) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Adder controls decode straight from state so reset silences them at once
   always_comb begin
      o_enb  = 1'b0;
      o_modo = c_MODO_HOLD;
      case (r_state)
`ifdef SECUENCIADOR_AUTOCLEAR_EN
         c_CLEAR: begin
            o_enb  = 1'b1;
            o_modo = c_MODO_CLEAR;
         end
`endif
         c_EXEC: begin
            o_enb  = 1'b1;
            o_modo = r_op;
         end
         c_WAIT: begin
            o_enb  = 1'b1;
            o_modo = c_MODO_HOLD;
         end
         default: begin
            o_enb  = 1'b0;
            o_modo = c_MODO_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_cin     <= 1'b0;
         r_op      <= 2'b00;
         r_res_q   <= '0;
         r_res_rco <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a   <= i_req_a;
            r_b   <= i_req_b;
            r_cin <= i_req_cin;
            r_op  <= i_req_op;
         end
         // The adder's Q is registered, so WAIT sees the value EXEC produced
         if (r_state == c_WAIT) begin
            r_res_q   <= i_q;
            r_res_rco <= i_rco;
         end
      end
   end

   assign o_a         = r_a;
   assign o_b         = r_b;
   assign o_cin       = r_cin;
   assign o_res_valid = (r_state == c_RESP);
   assign o_res_q     = r_res_q;
   assign o_res_rco   = r_res_rco;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_operaciones.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for secuenciador_operaciones: behavioural adder, vector table,
// random transactions against a transaction-level model, and reset/backpressure cases.
module tb_secuenciador_operaciones;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic       req_cin;
   logic [3:0] dut_a;
   logic [3:0] dut_b;
   logic       dut_cin;
   logic       dut_enb;
   logic [1:0] dut_modo;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_q;
   logic       res_rco;

   // Behavioural adder/accumulator; not reset by the sequencer's reset
   logic [3:0] add_q   = 4'h0;
   logic       add_rco = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level belief of the adder content
   logic [3:0] mdl_q   = 4'h0;
   logic       mdl_rco = 1'b0;

   typedef struct {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      int         hold;
      logic [3:0] exp_q;
      logic       exp_rco;
   } vec_t;

   vec_t vecs[7];

   secuenciador_operaciones #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_op    (req_op),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_cin   (req_cin),
      .o_a         (dut_a),
      .o_b         (dut_b),
      .o_cin       (dut_cin),
      .o_enb       (dut_enb),
      .o_modo      (dut_modo),
      .i_q         (add_q),
      .i_rco       (add_rco),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_q     (res_q),
      .o_res_rco   (res_rco)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dut_enb) begin
         case (dut_modo)
            2'b01:   {add_rco, add_q} <= {1'b0, dut_a} + {1'b0, dut_b} + {4'b0, dut_cin};
            2'b10:   {add_rco, add_q} <= {1'b0, dut_a} - {1'b0, dut_b} - {4'b0, dut_cin};
            2'b11:   {add_rco, add_q} <= 5'b0;
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void ref_apply(input logic [1:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic cin);
      int s;
      case (op)
         2'b01: begin
            s = int'(a) + int'(b) + int'(cin);
            mdl_q = s[3:0];
            mdl_rco = (s > 15);
         end
         2'b10: begin
            s = int'(a) - int'(b) - int'(cin);
            mdl_q = s[3:0];
            mdl_rco = (s < 0);
         end
         2'b11: begin
            mdl_q = 4'h0;
            mdl_rco = 1'b0;
         end
         default: ;
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op);
      if (op == 2'b00) return 1;
      if (op == 2'b11) return 2;
`ifdef SECUENCIADOR_AUTOCLEAR_EN
      return 3;
`else
      return 2;
`endif
   endfunction

   // Busy-cycle trace of {ENB, MODO}, oldest cycle in the upper bits
   function automatic logic [11:0] exp_seq(input logic [1:0] op);
      logic [11:0] s;
      if (op == 2'b00)      s = {9'b0, 3'b100};
      else if (op == 2'b11) s = {6'b0, 3'b111, 3'b100};
      else begin
`ifdef SECUENCIADOR_AUTOCLEAR_EN
         s = {3'b0, 3'b111, 1'b1, op, 3'b100};
`else
         s = {6'b0, 1'b1, op, 3'b100};
`endif
      end
      return s;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge, DUT idle
   task automatic do_txn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input int hold,
                         input logic [3:0] exp_q, input logic exp_rco);
      int          lat;
      logic [11:0] seq;
      logic        held_ok;
      logic        done;
      logic [3:0]  got_q;
      logic        got_rco;
      lat = 0;
      seq = '0;
      held_ok = 1'b1;
      done = 1'b0;
      for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
      chk("req_ready_before_txn", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      req_cin = cin;
      res_ready = (hold == 0);
      @(posedge clk);
      #1;
      // Keep a junk request pending: it must stall, not disturb A/B/Cin
      req_op = 2'($urandom);
      req_a = 4'($urandom);
      req_b = 4'($urandom);
      req_cin = 1'($urandom);
      for (int n = 0; n < 10 && !done; n++) begin
         @(negedge clk);
         if (res_valid) done = 1'b1;
         else begin
            lat++;
            seq = {seq[8:0], dut_enb, dut_modo};
            if (dut_a !== a || dut_b !== b || dut_cin !== cin || req_ready !== 1'b0)
               held_ok = 1'b0;
         end
      end
      chk("res_valid_timeout", {31'b0, done}, 32'd1);
      got_q = res_q;
      got_rco = res_rco;
      chk("latency", lat, exp_lat(op));
      chk("modo_sequence", {20'b0, seq}, {20'b0, exp_seq(op)});
      chk("operands_held", {31'b0, held_ok}, 32'd1);
      chk("res_q", {28'b0, got_q}, {28'b0, exp_q});
      chk("res_rco", {31'b0, got_rco}, {31'b0, exp_rco});
      for (int h = 0; h < hold; h++) begin
         chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
         chk("bp_res_q", {28'b0, res_q}, {28'b0, got_q});
         chk("bp_res_rco", {31'b0, res_rco}, {31'b0, got_rco});
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
         chk("bp_enb", {31'b0, dut_enb}, 32'd0);
         @(negedge clk);
      end
      chk("resp_still_valid", {31'b0, res_valid}, 32'd1);
      res_ready = 1'b1;
      @(negedge clk);
      chk("idle_res_valid", {31'b0, res_valid}, 32'd0);
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_enb"}, {31'b0, dut_enb}, 32'd0);
      chk({tag, "_modo"}, {30'b0, dut_modo}, 32'd0);
      chk({tag, "_a"}, {28'b0, dut_a}, 32'd0);
      chk({tag, "_b"}, {28'b0, dut_b}, 32'd0);
      chk({tag, "_cin"}, {31'b0, dut_cin}, 32'd0);
      chk({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
      chk({tag, "_res_q"}, {28'b0, res_q}, 32'd0);
      chk({tag, "_res_rco"}, {31'b0, res_rco}, 32'd0);
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;

      vecs[0] = '{2'b01, 4'b1110, 4'b1001, 1'b0, 0, 4'b0111, 1'b1};
      vecs[1] = '{2'b00, 4'b0000, 4'b0000, 1'b0, 0, 4'b0111, 1'b1};
      vecs[2] = '{2'b01, 4'b0110, 4'b1001, 1'b1, 0, 4'b0000, 1'b1};
      vecs[3] = '{2'b10, 4'b1110, 4'b1001, 1'b0, 5, 4'b0101, 1'b0};
      vecs[4] = '{2'b11, 4'b1010, 4'b0101, 1'b1, 0, 4'b0000, 1'b0};
      vecs[5] = '{2'b00, 4'b1111, 4'b1111, 1'b1, 0, 4'b0000, 1'b0};
      vecs[6] = '{2'b10, 4'b0011, 4'b0101, 1'b1, 1, 4'b1101, 1'b1};

      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 2'b00;
      req_a = 4'h0;
      req_b = 4'h0;
      req_cin = 1'b0;
      res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("req_ready_after_reset", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < 7; i++) begin
         ref_apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
         do_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
                vecs[i].exp_q, vecs[i].exp_rco);
      end

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = 4'($urandom);
         b = 4'($urandom);
         cin = 1'($urandom);
         ref_apply(op, a, b, cin);
         do_txn(op, a, b, cin, int'($urandom_range(0, 2)), mdl_q, mdl_rco);
      end

      // Reset while the add is executing: no result, adder keeps its value
      ref_apply(2'b01, 4'b0111, 4'b0110, 1'b0);
      do_txn(2'b01, 4'b0111, 4'b0110, 1'b0, 0, mdl_q, mdl_rco);
      req_valid = 1'b1;
      req_op = 2'b01;
      req_a = 4'b0101;
      req_b = 4'b0001;
      req_cin = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
`ifdef SECUENCIADOR_AUTOCLEAR_EN
      @(negedge clk);
      mdl_q = 4'h0;
      mdl_rco = 1'b0;
`endif
      chk("pre_reset_exec_modo", {30'b0, dut_modo}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midop_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("no_res_valid_after_reset", {31'b0, res_valid}, 32'd0);
      end
      do_txn(2'b00, 4'h0, 4'h0, 1'b0, 0, mdl_q, mdl_rco);
      ref_apply(2'b01, 4'b1000, 4'b1000, 1'b1);
      do_txn(2'b01, 4'b1000, 4'b1000, 1'b1, 0, mdl_q, mdl_rco);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
